// File: rtl/doorlock_pkg.sv
// Shared definitions for the doorlock display/entry path: controller state
// encoding and the special 4-bit digit codes understood by the segment decoders.
package doorlock_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ENTRY = 3'd1,
    ST_WAIT  = 3'd2,
    ST_OK    = 3'd3,
    ST_ERR   = 3'd4
  } state_t;

  localparam logic [3:0] BLANK_CODE = 4'hF;
  localparam logic [3:0] ZERO_CODE  = 4'h0;
  localparam logic [3:0] DIGIT_MAX  = 4'd9;

endpackage

// File: rtl/fnd_blink_timer.sv
// Terminal-count counter with a phase bit that toggles each time the count
// wraps; the caller selects the terminal value per state and clears on entry.
module fnd_blink_timer #(
  parameter int MAX_CNT = 100000000,
  parameter int CW      = $clog2(MAX_CNT)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_clr,
  input  logic [CW-1:0] i_last,
  output logic          o_tc,
  output logic          o_phase
);

  logic [CW-1:0] r_cnt;
  logic          r_phase;
  logic          w_tc;

  assign w_tc    = (r_cnt == i_last);
  assign o_tc    = w_tc;
  assign o_phase = r_phase;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt   <= '0;
      r_phase <= 1'b0;
    end else if (i_clr) begin
      r_cnt   <= '0;
      r_phase <= 1'b0;
    end else if (w_tc) begin
      r_cnt   <= '0;
      r_phase <= ~r_phase;
    end else begin
      r_cnt   <= r_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/fnd_entry_ctrl.sv
// Keypad entry buffer and 7-segment digit sequencer for the doorlock: collects
// the code, submits it to the checker and shows the OK / error result patterns.
module fnd_entry_ctrl import doorlock_pkg::*; #(
  parameter int DIGITS         = 4,
  parameter int BLINK_HALF     = 25000000,
  parameter int ERR_BLINKS     = 3,
  parameter int OK_HOLD        = 100000000,
  parameter int RESULT_TIMEOUT = 50000000
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                key_valid,
  input  logic [3:0]          key_digit,
  input  logic                key_clear,
  input  logic                key_enter,
  input  logic                result_ok,
  input  logic                result_err,
  output logic [4*DIGITS-1:0] pw_out,
  output logic                pw_valid,
  output logic [4*DIGITS-1:0] digit_code,
  output logic [2:0]          entry_count,
  output logic                busy
);

  localparam int W      = 4 * DIGITS;
  localparam int HALVES = 2 * ERR_BLINKS;
  localparam int HW     = $clog2(HALVES + 1);
  localparam int MAX_AB = (BLINK_HALF > OK_HOLD) ? BLINK_HALF : OK_HOLD;
  localparam int MAXC   = (MAX_AB > RESULT_TIMEOUT) ? MAX_AB : RESULT_TIMEOUT;
  localparam int CW     = $clog2(MAXC);
  localparam logic [CW-1:0] LAST_BLINK = CW'(BLINK_HALF - 1);
  localparam logic [CW-1:0] LAST_OK    = CW'(OK_HOLD - 1);
  localparam logic [CW-1:0] LAST_WAIT  = CW'(RESULT_TIMEOUT - 1);
  localparam logic [W-1:0]  BLANK_ALL  = {DIGITS{BLANK_CODE}};
  localparam logic [W-1:0]  ZERO_ALL   = {DIGITS{ZERO_CODE}};

  state_t          r_state, w_state_nxt;
  logic [W-1:0]    r_buf, w_buf_nxt;
  logic [W-1:0]    r_pw, w_pw_nxt;
  logic [W-1:0]    r_dc, w_dc_nxt;
  logic [2:0]      r_cnt, w_cnt_nxt;
  logic [HW-1:0]   r_half, w_half_nxt;
  logic            r_pv, w_pv_nxt;
  logic            r_busy;
  logic [CW-1:0]   w_last;
  logic            w_tc, w_phase, w_clr, w_phase_nxt, w_key_ok;

  assign w_key_ok = key_valid && (key_digit <= DIGIT_MAX);

  always_comb begin
    w_state_nxt = r_state;
    w_buf_nxt   = r_buf;
    w_cnt_nxt   = r_cnt;
    w_pw_nxt    = r_pw;
    w_pv_nxt    = 1'b0;
    w_half_nxt  = r_half;
    unique case (r_state)
      ST_IDLE: begin
        if (w_key_ok) begin
          w_buf_nxt   = {r_buf[W-5:0], key_digit};
          w_cnt_nxt   = 3'd1;
          w_state_nxt = ST_ENTRY;
        end
      end
      ST_ENTRY: begin
        // clear beats enter beats a new digit when they coincide
        if (key_clear) begin
          w_buf_nxt   = BLANK_ALL;
          w_cnt_nxt   = 3'd0;
          w_state_nxt = ST_IDLE;
        end else if (key_enter) begin
          if (r_cnt == 3'(DIGITS)) begin
            w_pw_nxt    = r_buf;
            w_pv_nxt    = 1'b1;
            w_state_nxt = ST_WAIT;
          end else begin
            w_state_nxt = ST_ERR;
          end
        end else if (w_key_ok && (r_cnt < 3'(DIGITS))) begin
          w_buf_nxt = {r_buf[W-5:0], key_digit};
          w_cnt_nxt = r_cnt + 3'd1;
        end
      end
      ST_WAIT: begin
        if (result_err)     w_state_nxt = ST_ERR;
        else if (result_ok) w_state_nxt = ST_OK;
        else if (w_tc)      w_state_nxt = ST_ERR;
      end
      ST_OK: begin
        if (w_tc) begin
          w_buf_nxt   = BLANK_ALL;
          w_cnt_nxt   = 3'd0;
          w_state_nxt = ST_IDLE;
        end
      end
      ST_ERR: begin
        if (w_tc) begin
          if (r_half == HW'(HALVES - 1)) begin
            w_buf_nxt   = BLANK_ALL;
            w_cnt_nxt   = 3'd0;
            w_state_nxt = ST_IDLE;
          end else begin
            w_half_nxt = r_half + 1'b1;
          end
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
    if (w_state_nxt != r_state) w_half_nxt = '0;
  end

  always_comb begin
    w_last = LAST_BLINK;
    case (r_state)
      ST_WAIT: w_last = LAST_WAIT;
      ST_OK:   w_last = LAST_OK;
      default: w_last = LAST_BLINK;
    endcase
  end

  // Timer restarts on every state change and idles while keys are being collected
  assign w_clr = (w_state_nxt != r_state) || (r_state == ST_IDLE) || (r_state == ST_ENTRY);
  assign w_phase_nxt = w_clr ? 1'b0 : (w_tc ? ~w_phase : w_phase);

  fnd_blink_timer #(
    .MAX_CNT (MAXC),
    .CW      (CW)
  ) u_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_clr   (w_clr),
    .i_last  (w_last),
    .o_tc    (w_tc),
    .o_phase (w_phase)
  );

  // Display is registered from next-state values so it moves with the state
  always_comb begin
    w_dc_nxt = BLANK_ALL;
    case (w_state_nxt)
      ST_ENTRY, ST_WAIT: w_dc_nxt = w_buf_nxt;
      ST_OK:             w_dc_nxt = ZERO_ALL;
      ST_ERR:            w_dc_nxt = w_phase_nxt ? w_buf_nxt : BLANK_ALL;
      default:           w_dc_nxt = BLANK_ALL;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_buf   <= BLANK_ALL;
      r_cnt   <= 3'd0;
      r_half  <= '0;
      r_pw    <= '0;
      r_pv    <= 1'b0;
      r_dc    <= BLANK_ALL;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_buf   <= w_buf_nxt;
      r_cnt   <= w_cnt_nxt;
      r_half  <= w_half_nxt;
      r_pw    <= w_pw_nxt;
      r_pv    <= w_pv_nxt;
      r_dc    <= w_dc_nxt;
      r_busy  <= (w_state_nxt == ST_WAIT) || (w_state_nxt == ST_OK) || (w_state_nxt == ST_ERR);
    end
  end

  assign pw_out      = r_pw;
  assign pw_valid    = r_pv;
  assign digit_code  = r_dc;
  assign entry_count = r_cnt;
  assign busy        = r_busy;

endmodule

// File: tb/tb_fnd_entry_ctrl.sv
// Scoreboard bench for fnd_entry_ctrl with shortened timer parameters.
module tb_fnd_entry_ctrl;

  localparam int DIGITS = 4;
  localparam int BH     = 4;
  localparam int EB     = 3;
  localparam int OKH    = 10;
  localparam int RT     = 20;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        key_valid, key_clear, key_enter, result_ok, result_err;
  logic [3:0]  key_digit;
  logic [15:0] pw_out, digit_code;
  logic        pw_valid, busy;
  logic [2:0]  entry_count;

  always #5 clk = ~clk;

  fnd_entry_ctrl #(
    .DIGITS(DIGITS), .BLINK_HALF(BH), .ERR_BLINKS(EB),
    .OK_HOLD(OKH), .RESULT_TIMEOUT(RT)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .key_valid(key_valid), .key_digit(key_digit),
    .key_clear(key_clear), .key_enter(key_enter),
    .result_ok(result_ok), .result_err(result_err),
    .pw_out(pw_out), .pw_valid(pw_valid),
    .digit_code(digit_code), .entry_count(entry_count), .busy(busy)
  );

  typedef struct {
    logic [15:0] dc;
    logic [2:0]  cnt;
    logic        busy;
    logic        pv;
    logic        pwchk;
    logic [15:0] pw;
  } exp_t;

  exp_t sb_q[$];
  int n_cmp = 0;
  int n_bad = 0;

  logic [15:0] e_dc;
  logic [2:0]  e_cnt;
  logic        e_busy, e_pv, e_pwchk;
  logic [15:0] e_pw;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic push_exp();
    exp_t x;
    x.dc = e_dc; x.cnt = e_cnt; x.busy = e_busy;
    x.pv = e_pv; x.pwchk = e_pwchk; x.pw = e_pw;
    sb_q.push_back(x);
  endtask

  task automatic compare_head();
    exp_t x;
    check("sb_depth", 32'(sb_q.size()), 32'd1);
    if (sb_q.size() > 0) begin
      x = sb_q.pop_front();
      check("digit_code", 32'(digit_code), 32'(x.dc));
      check("entry_count", 32'(entry_count), 32'(x.cnt));
      check("busy", 32'(busy), 32'(x.busy));
      check("pw_valid", 32'(pw_valid), 32'(x.pv));
      if (x.pwchk) check("pw_out", 32'(pw_out), 32'(x.pw));
    end
  endtask

  task automatic step(input logic kv, input logic [3:0] kd, input logic kc,
                      input logic ke, input logic rok, input logic rerr);
    key_valid = kv; key_digit = kd; key_clear = kc;
    key_enter = ke; result_ok = rok; result_err = rerr;
    push_exp();
    @(posedge clk); #1;
    key_valid = 1'b0; key_digit = 4'h0; key_clear = 1'b0;
    key_enter = 1'b0; result_ok = 1'b0; result_err = 1'b0;
    compare_head();
  endtask

  task automatic set_e(input logic [15:0] dc, input logic [2:0] cnt,
                       input logic b, input logic pv);
    e_dc = dc; e_cnt = cnt; e_busy = b; e_pv = pv;
  endtask

  task automatic key(input logic [3:0] d, input logic [15:0] dc, input logic [2:0] cnt);
    set_e(dc, cnt, 1'b0, 1'b0);
    step(1'b1, d, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  // ERR entry sample (blank) is done by the caller; this covers the rest.
  task automatic err_blink(input logic [15:0] bufv, input logic [2:0] cnt);
    e_pwchk = 1'b0;
    for (int i = 1; i < 2 * EB * BH; i++) begin
      set_e((((i / BH) % 2) == 0) ? 16'hFFFF : bufv, cnt, 1'b1, 1'b0);
      if (i == 2) step(1'b1, 4'h3, 1'b0, 1'b1, 1'b1, 1'b0);
      else        idle(1);
    end
    set_e(16'hFFFF, 3'd0, 1'b0, 1'b0);
    idle(1);
  endtask

  task automatic enter_full(input logic [15:0] code);
    set_e(code, 3'd4, 1'b1, 1'b1);
    e_pw = code; e_pwchk = 1'b1;
    step(1'b0, 4'h0, 1'b0, 1'b1, 1'b0, 1'b0);
    e_pv = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    key_valid = 1'b0; key_digit = 4'h0; key_clear = 1'b0;
    key_enter = 1'b0; result_ok = 1'b0; result_err = 1'b0;
    set_e(16'hFFFF, 3'd0, 1'b0, 1'b0);
    e_pw = 16'h0; e_pwchk = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    push_exp(); compare_head();
    rst_n = 1'b1;

    // 1: fill four digits, a fifth is dropped
    key(4'h1, 16'hFFF1, 3'd1);
    key(4'h2, 16'hFF12, 3'd2);
    key(4'h3, 16'hF123, 3'd3);
    key(4'h4, 16'h1234, 3'd4);
    key(4'h7, 16'h1234, 3'd4);

    // 2: clear, ignored inputs in IDLE, non-decimal keys, priority
    set_e(16'hFFFF, 3'd0, 1'b0, 1'b0);
    step(1'b0, 4'h0, 1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b0, 4'h0, 1'b0, 1'b1, 1'b1, 1'b1);
    key(4'hA, 16'hFFFF, 3'd0);
    key(4'h5, 16'hFFF5, 3'd1);
    key(4'hB, 16'hFFF5, 3'd1);
    key(4'h6, 16'hFF56, 3'd2);
    set_e(16'hFFFF, 3'd0, 1'b0, 1'b0);
    step(1'b1, 4'h8, 1'b1, 1'b1, 1'b0, 1'b0);

    // 3: submit and OK pattern
    key(4'h9, 16'hFFF9, 3'd1);
    key(4'h0, 16'hFF90, 3'd2);
    key(4'h1, 16'hF901, 3'd3);
    key(4'h2, 16'h9012, 3'd4);
    enter_full(16'h9012);
    step(1'b1, 4'h5, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 4'h0, 1'b1, 1'b1, 1'b0, 1'b0);
    idle(1);
    e_pwchk = 1'b0;
    set_e(16'h0000, 3'd4, 1'b1, 1'b0);
    step(1'b0, 4'h0, 1'b0, 1'b0, 1'b1, 1'b0);
    step(1'b1, 4'h1, 1'b0, 1'b0, 1'b0, 1'b0);
    idle(OKH - 2);
    set_e(16'hFFFF, 3'd0, 1'b0, 1'b0);
    idle(1);

    // 4: checker rejects
    key(4'h3, 16'hFFF3, 3'd1);
    key(4'h3, 16'hFF33, 3'd2);
    key(4'h3, 16'hF333, 3'd3);
    key(4'h3, 16'h3333, 3'd4);
    enter_full(16'h3333);
    e_pwchk = 1'b0;
    set_e(16'hFFFF, 3'd4, 1'b1, 1'b0);
    step(1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b1);
    err_blink(16'h3333, 3'd4);

    // 5a: short entry
    key(4'h1, 16'hFFF1, 3'd1);
    key(4'h2, 16'hFF12, 3'd2);
    set_e(16'hFFFF, 3'd2, 1'b1, 1'b0);
    step(1'b0, 4'h0, 1'b0, 1'b1, 1'b0, 1'b0);
    err_blink(16'hFF12, 3'd2);

    // 5b: no verdict, timeout
    key(4'h5, 16'hFFF5, 3'd1);
    key(4'h5, 16'hFF55, 3'd2);
    key(4'h5, 16'hF555, 3'd3);
    key(4'h5, 16'h5555, 3'd4);
    enter_full(16'h5555);
    idle(RT - 1);
    e_pwchk = 1'b0;
    set_e(16'hFFFF, 3'd4, 1'b1, 1'b0);
    idle(1);
    err_blink(16'h5555, 3'd4);

    // 5c/6: simultaneous verdicts, then asynchronous reset mid-ERR
    key(4'h7, 16'hFFF7, 3'd1);
    key(4'h7, 16'hFF77, 3'd2);
    key(4'h7, 16'hF777, 3'd3);
    key(4'h7, 16'h7777, 3'd4);
    enter_full(16'h7777);
    e_pwchk = 1'b0;
    set_e(16'hFFFF, 3'd4, 1'b1, 1'b0);
    step(1'b0, 4'h0, 1'b0, 1'b0, 1'b1, 1'b1);
    idle(BH - 1);
    set_e(16'h7777, 3'd4, 1'b1, 1'b0);
    idle(2);
    #2;
    rst_n = 1'b0;
    #1;
    set_e(16'hFFFF, 3'd0, 1'b0, 1'b0);
    e_pw = 16'h0; e_pwchk = 1'b1;
    push_exp(); compare_head();
    #3;
    rst_n = 1'b1;
    @(posedge clk); #1;
    step(1'b0, 4'h0, 1'b0, 1'b0, 1'b1, 1'b0);
    key(4'h8, 16'hFFF8, 3'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
